// File: rtl/demux_rr_scheduler.sv
// Round-robin sequencing controller for a 1xN demultiplexer.
//
// Accepts a 1-bit stream over a valid/ready handshake and steers each beat to
// one of N channels. The channel is picked round-robin among channels whose
// ready is high. An optional burst lock keeps BURST consecutive beats on one
// channel.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   enable      scheduler enable; 0 parks the FSM in IDLE
//   in_valid    source has a beat on in_data
//   in_data     data bit to distribute
//   ch_ready    per-channel ready
//   in_ready    combinational accept indication
//   sel         registered index of the last granted channel
//   y           registered demux output, in_data placed at bit sel
//   y_valid     registered one-hot strobe of the channel written last cycle
//   state       FSM state: 00 IDLE, 01 RUN, 10 LOCK
module demux_rr_scheduler #(
  parameter int unsigned N     = 8,
  parameter int unsigned BURST = 1,
  localparam int unsigned W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         in_valid,
  input  logic         in_data,
  input  logic [N-1:0] ch_ready,
  output logic         in_ready,
  output logic [W-1:0] sel,
  output logic [N-1:0] y,
  output logic [N-1:0] y_valid,
  output logic [1:0]   state
);

  localparam int unsigned CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BurstLast = CW'(BURST - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StLock = 2'b10
  } state_e;

  state_e         state_q;
  logic [W-1:0]   ptr_q;
  logic [CW-1:0]  beat_cnt_q;

  logic [W-1:0]   grant;
  logic           found;
  logic [N-1:0]   grant_oh;
  logic [W-1:0]   ptr_wrap;
  logic           burst_done;
  logic           xfer;

  // Grant search. The scan index wraps at N, not at 2^W, so non-power-of-two
  // channel counts never look at nonexistent channels.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = ptr_q;
    found = 1'b0;
    if (state_q == StLock) begin
      found = ch_ready[ptr_q];
    end else if (state_q == StRun) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = k + 32'(ptr_q);
        if (idx >= N) idx = idx - N;
        if (!found && ch_ready[W'(idx)]) begin
          found = 1'b1;
          grant = W'(idx);
        end
      end
    end
  end

  assign in_ready   = enable & found;
  assign xfer       = in_valid & in_ready;
  assign grant_oh   = {{(N-1){1'b0}}, 1'b1} << grant;
  assign ptr_wrap   = (grant == W'(N - 1)) ? '0 : grant + W'(1);
  assign burst_done = (beat_cnt_q == BurstLast);
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      sel        <= '0;
      y          <= '0;
      y_valid    <= '0;
    end else begin
      // Strobes are single-cycle; only a transfer re-arms them.
      y       <= '0;
      y_valid <= '0;
      case (state_q)
        StIdle: begin
          if (enable) state_q <= StRun;
        end
        default: begin
          if (!enable) begin
            // Abandon any partial burst; the pointer is kept so service
            // resumes where it left off.
            state_q    <= StIdle;
            beat_cnt_q <= '0;
          end else if (xfer) begin
            sel     <= grant;
            y_valid <= grant_oh;
            y       <= in_data ? grant_oh : '0;
            if (burst_done) begin
              ptr_q      <= ptr_wrap;
              beat_cnt_q <= '0;
              state_q    <= StRun;
            end else begin
              ptr_q      <= grant;
              beat_cnt_q <= beat_cnt_q + CW'(1);
              state_q    <= StLock;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
Sequencing controller for the 1xN demultiplexer. It accepts a 1-bit data stream with a valid/ready handshake and distributes each beat to one of N output channels. Channel choice is round-robin among channels that assert ready, with an optional burst lock that keeps BURST consecutive beats on one channel. It drives the registered select, one-hot strobe and demultiplexed data that the downstream consumers use.

Parameters:
N, 8, number of output channels (>=2, need not be a power of two)
BURST, 1, beats delivered to a granted channel before the pointer advances (>=1)
W, clog2(N) (local), select width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  scheduler enable; 0 = idle, no transfers
in_valid  in  1  source has a beat on in_data
in_data  in  1  data bit to distribute (din of the demux)
ch_ready  in  N  per-channel ready; bit j = channel j can accept a beat
in_ready  out  1  combinational; a beat is accepted this cycle when in_valid=1
sel  out  W  registered; last granted channel index
y  out  N  registered demux output; in_data placed at bit sel, all other bits 0
y_valid  out  N  registered one-hot strobe of the channel written this cycle
state  out  2  FSM state: 00 IDLE, 01 RUN, 10 LOCK

Behaviour:
- Reset (rst_n=0, asynchronous): ptr=0, beat_cnt=0, state=IDLE, sel=0, y=0, y_valid=0. in_ready=0 while in reset.
- Internal registers:
  - ptr (W bits): next candidate channel.
  - beat_cnt (clog2(BURST+1) bits): beats already delivered in the current burst.
- Grant search (combinational):
  - In RUN, g = first index j scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 with ch_ready[j]=1. Wrap is modulo N, not 2^W.
  - In LOCK, the only candidate is g=ptr.
- in_ready = enable & (state != IDLE) & (RUN: |ch_ready ; LOCK: ch_ready[ptr]).
- Transfer xfer = in_valid & in_ready.
- On xfer, at the next edge (latency 1 cycle):
  - sel <= g
  - y_valid <= one-hot(g)
  - y <= in_data ? one-hot(g) : 0
- Pointer update on xfer:
  - If beat_cnt+1 == BURST: ptr <= (g==N-1) ? 0 : g+1, and beat_cnt <= 0.
  - Otherwise: ptr <= g, beat_cnt <= beat_cnt+1.
- No xfer: y <= 0, y_valid <= 0; sel, ptr and beat_cnt hold.
- FSM:
  - IDLE -> RUN when enable=1. The first accept can occur in the cycle after enable rises.
  - RUN -> LOCK on an xfer that leaves beat_cnt>0 after update (BURST>1 only).
  - LOCK -> RUN on the xfer that completes the burst.
  - RUN/LOCK -> IDLE when enable=0. Leaving for IDLE clears beat_cnt and holds ptr. No xfer happens in the cycle enable=0.
- With BURST=1, LOCK is never entered.
- In LOCK with ch_ready[ptr]=0: stall (in_ready=0) and stay locked. Other ready channels are not served.
- in_valid=0: no state change except the FSM enable rule.
- Simultaneous ch_ready change and xfer: the grant uses the current-cycle ch_ready only.
- rst_n asserted mid-burst: all state returns to reset values immediately. No y_valid pulse is emitted.
- y_valid is always one-hot or zero. y is always a subset of y_valid.

Test Plan:
1. Reset check: rst_n=0 then released, enable=0, in_valid=1, ch_ready=8'hFF -> y=0, y_valid=0, sel=0, in_ready=0, state=IDLE for all cycles.
2. Round-robin, N=8, BURST=1: enable=1, in_valid=1, in_data=1 for 10 cycles, ch_ready=8'hFF -> sel sequence 0,1,...,7,0,1; y_valid=y=1<<sel, one cycle after each accept.
3. Skip not-ready: ch_ready=8'b1010_0100, ptr=0, in_data alternating 1,0 -> grants 2,5,7,2; y=00000100, then 00000000 with y_valid=00100000, and so on.
4. Burst lock, BURST=2: ch_ready=8'hFF -> sel 0,0,1,1,2; state RUN,LOCK,RUN,LOCK. Dropping ch_ready[1] while LOCK on channel 1 -> in_ready=0, stall until bit 1 returns, with no grant to channel 2.
5. Wrap/non-power-of-2: N=5, ch_ready=5'b10001, ptr=4 -> grants 4,0,4,0 (never index 5-7).
6. Abort: rst_n pulsed low mid-burst (BURST=2, beat_cnt=1), or enable dropped -> outputs 0 asynchronously on reset. On enable drop, state=IDLE and beat_cnt=0; on re-enable the next grant starts a fresh burst at the held ptr.
